// File: rtl/alu_operand_shifter_pkg.sv
// Shared types and helpers for the ALU operand shifter (barrel shifter feeding ALU b_in).
package alu_operand_shifter_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        SHIFT_LSL = 2'b00,
        SHIFT_LSR = 2'b01,
        SHIFT_ASR = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_type_e;

    function automatic logic [DEFAULT_DATA_WIDTH-1:0] ror_word(
        input logic [DEFAULT_DATA_WIDTH-1:0] v,
        input logic [4:0]                    n
    );
        logic [2*DEFAULT_DATA_WIDTH-1:0] d;
        d = {v, v} >> n;
        return d[DEFAULT_DATA_WIDTH-1:0];
    endfunction

    // Returns {carry, result}; valid for amounts 1..31 only, zero amounts are special-cased by callers.
    function automatic logic [DEFAULT_DATA_WIDTH:0] shift_nonzero(
        input shift_type_e                   st,
        input logic [DEFAULT_DATA_WIDTH-1:0] v,
        input logic [4:0]                    n
    );
        logic [DEFAULT_DATA_WIDTH:0]   t;
        logic [DEFAULT_DATA_WIDTH-1:0] r;
        case (st)
            SHIFT_LSL: t = {1'b0, v} << n;
            SHIFT_LSR: begin
                t = {v, 1'b0} >> n;
                t = {t[0], t[DEFAULT_DATA_WIDTH:1]};
            end
            SHIFT_ASR: begin
                t = $signed({v, 1'b0}) >>> n;
                t = {t[0], t[DEFAULT_DATA_WIDTH:1]};
            end
            SHIFT_ROR: begin
                r = ror_word(v, n);
                t = {r[DEFAULT_DATA_WIDTH-1], r};
            end
            default: t = {1'b0, v};
        endcase
        return t;
    endfunction

endpackage

// File: rtl/alu_operand_shifter_if.sv
// Request/response bundle between the issue stage, the operand shifter and the ALU.
interface alu_operand_shifter_if
    import alu_operand_shifter_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] rm_data;
    logic                  imm_mode;
    logic [7:0]            imm8;
    logic [3:0]            rot4;
    logic [1:0]            shift_type;
    logic [4:0]            shift_imm;
    logic                  shift_reg_mode;
    logic [7:0]            rs_byte;
    logic                  cin;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] b_out;
    logic                  shift_carry;

    modport master (
        output in_valid, rm_data, imm_mode, imm8, rot4, shift_type, shift_imm,
               shift_reg_mode, rs_byte, cin, out_ready,
        input  in_ready, out_valid, b_out, shift_carry
    );

    modport slave (
        input  in_valid, rm_data, imm_mode, imm8, rot4, shift_type, shift_imm,
               shift_reg_mode, rs_byte, cin, out_ready,
        output in_ready, out_valid, b_out, shift_carry
    );
endinterface

// File: rtl/alu_operand_shifter_core.sv
// Combinational shift/carry logic. Register-specified amounts exist only when
// ALU_SHIFT_REG_AMT_EN is defined; otherwise shift_reg_mode/rs_byte are ignored.
module alu_shift_core
    import alu_operand_shifter_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] rm_data,
    input  logic                  imm_mode,
    input  logic [7:0]            imm8,
    input  logic [3:0]            rot4,
    input  shift_type_e           shift_type,
    input  logic [4:0]            shift_imm,
    input  logic                  shift_reg_mode,
    input  logic [7:0]            rs_byte,
    input  logic                  cin,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  carry
);
    logic [DATA_WIDTH-1:0] imm_rot_s;
    logic [DATA_WIDTH:0]   imm_shift_s;
    logic [DATA_WIDTH-1:0] amt_res_s;
    logic                  amt_c_s;

    // Rotated-immediate value and the generic nonzero immediate-amount shift
    always_comb begin
        imm_rot_s   = ror_word({24'd0, imm8}, {rot4, 1'b0});
        imm_shift_s = shift_nonzero(shift_type, rm_data, shift_imm);
    end

    // Immediate-amount form; a zero amount encodes LSR/ASR #32 and RRX
    always_comb begin
        amt_res_s = imm_shift_s[DATA_WIDTH-1:0];
        amt_c_s   = imm_shift_s[DATA_WIDTH];
        if (shift_imm == 5'd0) begin
            case (shift_type)
                SHIFT_LSL: begin amt_res_s = rm_data;                     amt_c_s = cin;         end
                SHIFT_LSR: begin amt_res_s = {DATA_WIDTH{1'b0}};          amt_c_s = rm_data[31]; end
                SHIFT_ASR: begin amt_res_s = {DATA_WIDTH{rm_data[31]}};   amt_c_s = rm_data[31]; end
                SHIFT_ROR: begin amt_res_s = {cin, rm_data[31:1]};        amt_c_s = rm_data[0];  end
                default:   begin amt_res_s = rm_data;                     amt_c_s = cin;         end
            endcase
        end else begin
            amt_res_s = imm_shift_s[DATA_WIDTH-1:0];
            amt_c_s   = imm_shift_s[DATA_WIDTH];
        end
    end

`ifdef ALU_SHIFT_REG_AMT_EN
    logic [DATA_WIDTH:0]   reg_shift_s;
    logic [DATA_WIDTH-1:0] reg_res_s;
    logic                  reg_c_s;

    // Register-specified amount: full 8-bit range with saturating behaviour past 32
    always_comb begin
        reg_shift_s = shift_nonzero(shift_type, rm_data, rs_byte[4:0]);
        reg_res_s   = reg_shift_s[DATA_WIDTH-1:0];
        reg_c_s     = reg_shift_s[DATA_WIDTH];
        if (rs_byte == 8'd0) begin
            reg_res_s = rm_data;
            reg_c_s   = cin;
        end else begin
            case (shift_type)
                SHIFT_LSL: begin
                    if (rs_byte == 8'd32) begin
                        reg_res_s = {DATA_WIDTH{1'b0}}; reg_c_s = rm_data[0];
                    end else if (rs_byte > 8'd32) begin
                        reg_res_s = {DATA_WIDTH{1'b0}}; reg_c_s = 1'b0;
                    end else begin
                        reg_res_s = reg_shift_s[DATA_WIDTH-1:0]; reg_c_s = reg_shift_s[DATA_WIDTH];
                    end
                end
                SHIFT_LSR: begin
                    if (rs_byte == 8'd32) begin
                        reg_res_s = {DATA_WIDTH{1'b0}}; reg_c_s = rm_data[31];
                    end else if (rs_byte > 8'd32) begin
                        reg_res_s = {DATA_WIDTH{1'b0}}; reg_c_s = 1'b0;
                    end else begin
                        reg_res_s = reg_shift_s[DATA_WIDTH-1:0]; reg_c_s = reg_shift_s[DATA_WIDTH];
                    end
                end
                SHIFT_ASR: begin
                    if (rs_byte >= 8'd32) begin
                        reg_res_s = {DATA_WIDTH{rm_data[31]}}; reg_c_s = rm_data[31];
                    end else begin
                        reg_res_s = reg_shift_s[DATA_WIDTH-1:0]; reg_c_s = reg_shift_s[DATA_WIDTH];
                    end
                end
                SHIFT_ROR: begin
                    if (rs_byte[4:0] == 5'd0) begin
                        reg_res_s = rm_data; reg_c_s = rm_data[31];
                    end else begin
                        reg_res_s = reg_shift_s[DATA_WIDTH-1:0]; reg_c_s = reg_shift_s[DATA_WIDTH];
                    end
                end
                default: begin reg_res_s = rm_data; reg_c_s = cin; end
            endcase
        end
    end

    // Output select: immediate form wins over the register-amount form
    always_comb begin
        if (imm_mode) begin
            result = imm_rot_s;
            carry  = (rot4 == 4'd0) ? cin : imm_rot_s[31];
        end else if (shift_reg_mode) begin
            result = reg_res_s;
            carry  = reg_c_s;
        end else begin
            result = amt_res_s;
            carry  = amt_c_s;
        end
    end
`else
    logic unused_s;
    assign unused_s = ^{shift_reg_mode, rs_byte};

    // Output select between rotated-immediate and immediate-amount forms
    always_comb begin
        if (imm_mode) begin
            result = imm_rot_s;
            carry  = (rot4 == 4'd0) ? cin : imm_rot_s[31];
        end else begin
            result = amt_res_s;
            carry  = amt_c_s;
        end
    end
`endif

endmodule

// File: rtl/alu_operand_shifter.sv
// Operand shifter stage: one-deep registered output with valid/ready handshake.
// Optional register-amount shifts via ALU_SHIFT_REG_AMT_EN (see alu_shift_core).
module alu_operand_shifter
    import alu_operand_shifter_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_operand_shifter_if.slave bus
);
    logic [DATA_WIDTH-1:0] result_s;
    logic                  carry_s;
    logic                  ready_s;
    logic                  accept_s;
    logic [DATA_WIDTH-1:0] b_r;
    logic                  carry_r;
    logic                  valid_r;

    alu_shift_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
        .rm_data        (bus.rm_data),
        .imm_mode       (bus.imm_mode),
        .imm8           (bus.imm8),
        .rot4           (bus.rot4),
        .shift_type     (shift_type_e'(bus.shift_type)),
        .shift_imm      (bus.shift_imm),
        .shift_reg_mode (bus.shift_reg_mode),
        .rs_byte        (bus.rs_byte),
        .cin            (bus.cin),
        .result         (result_s),
        .carry          (carry_s)
    );

    // Ready while empty or draining; also held high during reset
    always_comb begin
        ready_s  = !rst_n || !valid_r || bus.out_ready;
        accept_s = bus.in_valid && ready_s;
    end

    // Output register: load on accept, drop on consume, hold while stalled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            b_r     <= {DATA_WIDTH{1'b0}};
            carry_r <= 1'b0;
        end else if (accept_s) begin
            valid_r <= 1'b1;
            b_r     <= result_s;
            carry_r <= carry_s;
        end else if (bus.out_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign bus.in_ready    = ready_s;
    assign bus.out_valid   = valid_r;
    assign bus.b_out       = b_r;
    assign bus.shift_carry = carry_r;

endmodule

// File: tb/tb_alu_operand_shifter.sv
// Directed bench for alu_operand_shifter with a behavioural reference model and per-cycle compare.
module tb_alu_operand_shifter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    alu_operand_shifter_if bus ();
    alu_operand_shifter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference shifts written from the architectural rules; amounts are plain integers.
    function automatic logic [32:0] m_lsl(input logic [31:0] rm, input int a, input logic c);
        if (a == 0)  return {c, rm};
        if (a > 32)  return 33'd0;
        if (a == 32) return {rm[0], 32'd0};
        return {rm[32-a], rm << a};
    endfunction
    function automatic logic [32:0] m_lsr(input logic [31:0] rm, input int a, input logic c);
        if (a == 0)  return {c, rm};
        if (a > 32)  return 33'd0;
        if (a == 32) return {rm[31], 32'd0};
        return {rm[a-1], rm >> a};
    endfunction
    function automatic logic [32:0] m_asr(input logic [31:0] rm, input int a, input logic c);
        if (a == 0)  return {c, rm};
        if (a >= 32) return {rm[31], {32{rm[31]}}};
        return {rm[a-1], 32'($signed(rm) >>> a)};
    endfunction
    function automatic logic [32:0] m_ror(input logic [31:0] rm, input int a, input logic c);
        int k;
        logic [31:0] r;
        if (a == 0) return {c, rm};
        k = a % 32;
        if (k == 0) return {rm[31], rm};
        r = (rm >> k) | (rm << (32 - k));
        return {r[31], r};
    endfunction

    function automatic logic [32:0] ref_shift(input logic im, input logic [7:0] i8, input logic [3:0] r4,
                                              input logic [1:0] st, input logic [4:0] sh, input logic srm,
                                              input logic [7:0] rs, input logic c, input logic [31:0] rm);
        logic [63:0] w;
        logic [31:0] r;
        int a;
        if (im) begin
            a = 2 * int'(r4);
            w = {56'd0, i8};
            r = 32'((w >> a) | (w << (32 - a)));
            return {(r4 == 4'd0) ? c : r[31], r};
        end
`ifdef ALU_SHIFT_REG_AMT_EN
        if (srm) begin
            a = int'(rs);
            case (st)
                2'b00:   return m_lsl(rm, a, c);
                2'b01:   return m_lsr(rm, a, c);
                2'b10:   return m_asr(rm, a, c);
                default: return m_ror(rm, a, c);
            endcase
        end
`else
        if (srm && rs == 8'hFF && 1'b0) return 33'd0;
`endif
        a = int'(sh);
        case (st)
            2'b00:   return m_lsl(rm, a, c);
            2'b01:   return m_lsr(rm, (a == 0) ? 32 : a, c);
            2'b10:   return m_asr(rm, (a == 0) ? 32 : a, c);
            default: return (a == 0) ? {rm[0], c, rm[31:1]} : m_ror(rm, a, c);
        endcase
    endfunction

    // Transaction-level model of the output register
    logic        m_valid = 1'b0;
    logic [32:0] m_data = 33'd0;
    logic        started = 1'b0;
    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= 33'd0;
            started <= 1'b1;
        end else if (bus.in_valid && (!m_valid || bus.out_ready)) begin
            m_valid <= 1'b1;
            m_data  <= ref_shift(bus.imm_mode, bus.imm8, bus.rot4, bus.shift_type, bus.shift_imm,
                                 bus.shift_reg_mode, bus.rs_byte, bus.cin, bus.rm_data);
        end else if (bus.out_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (started) begin
            chk("cyc out_valid", {32'd0, bus.out_valid}, {32'd0, m_valid});
            chk("cyc in_ready", {32'd0, bus.in_ready}, {32'd0, (!rst_n || !m_valid || bus.out_ready)});
            if (m_valid) chk("cyc data", {bus.shift_carry, bus.b_out}, m_data);
        end
    end

    task automatic setv(input logic im, input logic [7:0] i8, input logic [3:0] r4, input logic [1:0] st,
                        input logic [4:0] sh, input logic srm, input logic [7:0] rs, input logic c,
                        input logic [31:0] rm);
        bus.imm_mode = im; bus.imm8 = i8; bus.rot4 = r4; bus.shift_type = st; bus.shift_imm = sh;
        bus.shift_reg_mode = srm; bus.rs_byte = rs; bus.cin = c; bus.rm_data = rm;
    endtask

    task automatic vec(input string nm, input logic im, input logic [7:0] i8, input logic [3:0] r4,
                       input logic [1:0] st, input logic [4:0] sh, input logic srm, input logic [7:0] rs,
                       input logic c, input logic [31:0] rm, input logic [31:0] eb, input logic ec);
        chk({nm, " model"}, ref_shift(im, i8, r4, st, sh, srm, rs, c, rm), {ec, eb});
        @(posedge clk); #1;
        setv(im, i8, r4, st, sh, srm, rs, c, rm);
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk({nm, " valid"}, {32'd0, bus.out_valid}, 33'd1);
        chk({nm, " b_out"}, {1'b0, bus.b_out}, {1'b0, eb});
        chk({nm, " carry"}, {32'd0, bus.shift_carry}, {32'd0, ec});
    endtask

    initial begin
        setv(1'b1, 8'hFF, 4'd4, 2'b00, 5'd0, 1'b0, 8'd0, 1'b0, 32'd0);
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst out_valid", {32'd0, bus.out_valid}, 33'd0);
        chk("rst b_out", {1'b0, bus.b_out}, 33'd0);
        chk("rst carry", {32'd0, bus.shift_carry}, 33'd0);
        chk("rst in_ready", {32'd0, bus.in_ready}, 33'd1);
        rst_n = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1;

        vec("imm ff r4", 1'b1, 8'hFF, 4'd4, 2'b00, 5'd0, 1'b0, 8'd0, 1'b0, 32'h0,        32'hFF000000, 1'b1);
        vec("imm r0 cin", 1'b1, 8'h3F, 4'd0, 2'b00, 5'd0, 1'b0, 8'd0, 1'b1, 32'h0,       32'h0000003F, 1'b1);
        vec("lsl 4",     1'b0, 8'h00, 4'd0, 2'b00, 5'd4, 1'b0, 8'd0, 1'b0, 32'hF0000001, 32'h00000010, 1'b1);
        vec("lsr 32",    1'b0, 8'h00, 4'd0, 2'b01, 5'd0, 1'b0, 8'd0, 1'b0, 32'h80000000, 32'h00000000, 1'b1);
        vec("rrx",       1'b0, 8'h00, 4'd0, 2'b11, 5'd0, 1'b0, 8'd0, 1'b1, 32'h00000003, 32'h80000001, 1'b1);
        vec("asr 32",    1'b0, 8'h00, 4'd0, 2'b10, 5'd0, 1'b0, 8'd0, 1'b0, 32'h80000000, 32'hFFFFFFFF, 1'b1);
        vec("lsr 8",     1'b0, 8'h00, 4'd0, 2'b01, 5'd8, 1'b0, 8'd0, 1'b1, 32'h12345678, 32'h00123456, 1'b0);
        vec("asr 4",     1'b0, 8'h00, 4'd0, 2'b10, 5'd4, 1'b0, 8'd0, 1'b0, 32'h8000000F, 32'hF8000000, 1'b1);
        vec("ror 8",     1'b0, 8'h00, 4'd0, 2'b11, 5'd8, 1'b0, 8'd0, 1'b1, 32'h12345678, 32'h78123456, 1'b0);
        vec("lsl 0",     1'b0, 8'h00, 4'd0, 2'b00, 5'd0, 1'b0, 8'd0, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1);
        vec("lsl 31",    1'b0, 8'h00, 4'd0, 2'b00, 5'd31, 1'b0, 8'd0, 1'b0, 32'h00000003, 32'h80000000, 1'b1);
        vec("imm prio",  1'b1, 8'h01, 4'd1, 2'b00, 5'd0, 1'b1, 8'd33, 1'b0, 32'h1,       32'h40000000, 1'b0);
`ifdef ALU_SHIFT_REG_AMT_EN
        vec("rlsl 32",   1'b0, 8'h00, 4'd0, 2'b00, 5'd4, 1'b1, 8'd32, 1'b0, 32'h00000001, 32'h00000000, 1'b1);
        vec("rlsl 33",   1'b0, 8'h00, 4'd0, 2'b00, 5'd4, 1'b1, 8'd33, 1'b1, 32'h00000001, 32'h00000000, 1'b0);
        vec("rror 64",   1'b0, 8'h00, 4'd0, 2'b11, 5'd4, 1'b1, 8'd64, 1'b0, 32'h80000000, 32'h80000000, 1'b1);
        vec("rasr 40",   1'b0, 8'h00, 4'd0, 2'b10, 5'd4, 1'b1, 8'd40, 1'b1, 32'h7FFFFFFF, 32'h00000000, 1'b0);
        vec("rlsr 0",    1'b0, 8'h00, 4'd0, 2'b01, 5'd4, 1'b1, 8'd0,  1'b1, 32'h00000005, 32'h00000005, 1'b1);
        vec("rror 36",   1'b0, 8'h00, 4'd0, 2'b11, 5'd0, 1'b1, 8'd36, 1'b0, 32'h0000000F, 32'hF0000000, 1'b1);
`else
        vec("srm ignored", 1'b0, 8'h00, 4'd0, 2'b00, 5'd4, 1'b1, 8'd33, 1'b1, 32'h00000001, 32'h00000010, 1'b0);
`endif

        // Stall for three cycles with a pending request, then release without a bubble
        @(posedge clk); #1;
        setv(1'b0, 8'h00, 4'd0, 2'b00, 5'd1, 1'b0, 8'd0, 1'b0, 32'h1);
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        setv(1'b0, 8'h00, 4'd0, 2'b00, 5'd2, 1'b0, 8'd0, 1'b0, 32'h1);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall in_ready", {32'd0, bus.in_ready}, 33'd0);
            chk("stall b_out", {1'b0, bus.b_out}, 33'h2);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        setv(1'b0, 8'h00, 4'd0, 2'b00, 5'd3, 1'b0, 8'd0, 1'b0, 32'h1);
        @(negedge clk);
        chk("release b_out", {1'b0, bus.b_out}, 33'h4);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("nobubble valid", {32'd0, bus.out_valid}, 33'd1);
        chk("nobubble b_out", {1'b0, bus.b_out}, 33'h8);

        // Reset while holding a stalled result
        @(posedge clk); #1;
        setv(1'b0, 8'h00, 4'd0, 2'b11, 5'd4, 1'b0, 8'd0, 1'b0, 32'h000000A5);
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        @(negedge clk);
        chk("held in_ready", {32'd0, bus.in_ready}, 33'd0);
        chk("held b_out", {1'b0, bus.b_out}, 33'h5000000A);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst2 out_valid", {32'd0, bus.out_valid}, 33'd0);
        chk("rst2 b_out", {1'b0, bus.b_out}, 33'd0);
        chk("rst2 in_ready", {32'd0, bus.in_ready}, 33'd1);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
